// File: rtl/datapath_fsm.sv
// datapath_fsm: Moore sequencer for the register-file/ALU datapath.
// Strobes are registered, computed from next state and latched instruction.
module datapath_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic       err,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic [1:0] ALUop,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel
);

  typedef enum logic [2:0] {
    WAIT, DECODE, WRITE_IMM, GET_A,
    GET_B, EXEC, WRITE_REG, HALT
  } state_t;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic [1:0] alu_op;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
  } ctl_t;

  function automatic logic is_movi(
    logic [2:0] c, logic [1:0] o);
    return c == 3'b110 && o == 2'b10;
  endfunction

  function automatic logic is_movr(
    logic [2:0] c, logic [1:0] o);
    return c == 3'b110 && o == 2'b00;
  endfunction

  function automatic logic is_arith(
    logic [2:0] c);
    return c == 3'b101;
  endfunction

  function automatic logic is_cmp(
    logic [2:0] c, logic [1:0] o);
    return c == 3'b101 && o == 2'b01;
  endfunction

  function automatic logic is_mvn(
    logic [2:0] c, logic [1:0] o);
    return c == 3'b101 && o == 2'b11;
  endfunction

  function automatic state_t next_of(
    state_t st, logic go,
    logic [2:0] c, logic [1:0] o);
    state_t nx;
    nx = WAIT;
    unique case (st)
      WAIT:      nx = go ? DECODE : WAIT;
      DECODE: begin
        unique case (1'b1)
          is_movi(c, o):
            nx = WRITE_IMM;
          is_movr(c, o) || is_mvn(c, o):
            nx = GET_B;
          is_arith(c) && !is_mvn(c, o):
            nx = GET_A;
          default:
            nx = ILLEGAL_TRAP ? HALT : WAIT;
        endcase
      end
      WRITE_IMM: nx = WAIT;
      GET_A:     nx = GET_B;
      GET_B:     nx = EXEC;
      EXEC:      nx = is_cmp(c, o) ? WAIT : WRITE_REG;
      WRITE_REG: nx = WAIT;
      HALT:      nx = HALT;
      default:   nx = WAIT;
    endcase
    return nx;
  endfunction

  function automatic ctl_t ctl_of(
    state_t st,
    logic [2:0] c, logic [1:0] o);
    ctl_t k;
    logic legal;
    k = '0;
    legal = is_movi(c, o) || is_movr(c, o)
          || is_arith(c);
    unique case (st)
      WAIT:      k.w = 1'b1;
      DECODE:    k.err = !legal;
      WRITE_IMM: begin
        k.nsel  = 3'b001;
        k.vsel  = 2'b10;
        k.write = 1'b1;
      end
      GET_A: begin
        k.nsel  = 3'b001;
        k.loada = 1'b1;
      end
      GET_B: begin
        k.nsel  = 3'b100;
        k.loadb = 1'b1;
      end
      EXEC: begin
        k.alu_op = is_movr(c, o) ? 2'b00 : o;
        k.asel   = is_movr(c, o) || is_mvn(c, o);
        k.loads  = is_cmp(c, o);
        k.loadc  = !is_cmp(c, o);
      end
      WRITE_REG: begin
        k.nsel  = 3'b010;
        k.write = 1'b1;
      end
      HALT:      k.err = 1'b1;
      default:   k = '0;
    endcase
    return k;
  endfunction

  state_t     state;
  state_t     nxt;
  logic [2:0] lat_opc;
  logic [1:0] lat_op;
  logic [2:0] opc_n;
  logic [1:0] op_n;
  logic       go;
  ctl_t       ctl;

  // Capture happens on the same edge that leaves WAIT
  assign go    = state == WAIT && s;
  assign opc_n = go ? opcode : lat_opc;
  assign op_n  = go ? op : lat_op;
  assign nxt   = next_of(state, go, lat_opc, lat_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT;
      lat_opc <= '0;
      lat_op  <= '0;
      ctl     <= ctl_of(WAIT, 3'b000, 2'b00);
    end else begin
      state   <= nxt;
      lat_opc <= opc_n;
      lat_op  <= op_n;
      ctl     <= ctl_of(nxt, opc_n, op_n);
    end
  end

  assign w     = ctl.w;
  assign err   = ctl.err;
  assign nsel  = ctl.nsel;
  assign vsel  = ctl.vsel;
  assign ALUop = ctl.alu_op;
  assign write = ctl.write;
  assign loada = ctl.loada;
  assign loadb = ctl.loadb;
  assign loadc = ctl.loadc;
  assign loads = ctl.loads;
  assign asel  = ctl.asel;
  assign bsel  = 1'b0;

endmodule

// File: tb/tb_datapath_fsm.sv
// tb_datapath_fsm: random and directed stimulus against a
// per-instruction strobe-sequence table, for both trap settings.
module tb_datapath_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s = 1'b0;
  logic [2:0] opcode = '0;
  logic [1:0] op = '0;

  logic       w0, err0, write0, loada0, loadb0;
  logic       loadc0, loads0, asel0, bsel0;
  logic [2:0] nsel0;
  logic [1:0] vsel0, alu0;
  logic       w1, err1, write1, loada1, loadb1;
  logic       loadc1, loads1, asel1, bsel1;
  logic [2:0] nsel1;
  logic [1:0] vsel1, alu1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  datapath_fsm #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .s(s),
    .opcode(opcode), .op(op),
    .w(w0), .err(err0), .nsel(nsel0),
    .vsel(vsel0), .ALUop(alu0),
    .write(write0), .loada(loada0),
    .loadb(loadb0), .loadc(loadc0),
    .loads(loads0), .asel(asel0),
    .bsel(bsel0)
  );

  datapath_fsm #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .s(s),
    .opcode(opcode), .op(op),
    .w(w1), .err(err1), .nsel(nsel1),
    .vsel(vsel1), .ALUop(alu1),
    .write(write1), .loada(loada1),
    .loadb(loadb1), .loadc(loadc1),
    .loads(loads1), .asel(asel1),
    .bsel(bsel1)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // {w,err,nsel,vsel,alu,write,la,lb,lc,ls,asel,bsel}
  function automatic logic [15:0] vec(
    logic wv, logic ev, logic [2:0] n,
    logic [1:0] vs, logic [1:0] a,
    logic [6:0] st);
    return {wv, ev, n, vs, a, st};
  endfunction

  localparam logic [15:0] IDLE =
    16'b1_0_000_00_00_0000000;
  localparam logic [15:0] HALTV =
    16'b0_1_000_00_00_0000000;

  function automatic int seq_len(
    logic [2:0] c, logic [1:0] o);
    if (c == 3'b110 && o == 2'b10) return 2;
    if (c == 3'b110 && o == 2'b00) return 4;
    if (c == 3'b101 && o == 2'b11) return 4;
    if (c == 3'b101 && o == 2'b01) return 4;
    if (c == 3'b101) return 5;
    return 1;
  endfunction

  function automatic logic [15:0] seq_at(
    logic [2:0] c, logic [1:0] o, int k);
    logic movi, movr, mvn, cmp, legal;
    int j;
    movi  = c == 3'b110 && o == 2'b10;
    movr  = c == 3'b110 && o == 2'b00;
    mvn   = c == 3'b101 && o == 2'b11;
    cmp   = c == 3'b101 && o == 2'b01;
    legal = movi || movr || c == 3'b101;
    if (k == 0)
      return vec(0, !legal, 3'b000, 2'b00,
                 2'b00, 7'b0);
    if (movi)
      return vec(0, 0, 3'b001, 2'b10, 2'b00,
                 7'b1000000);
    j = (movr || mvn) ? k + 1 : k;
    case (j)
      1: return vec(0, 0, 3'b001, 2'b00, 2'b00,
                    7'b0100000);
      2: return vec(0, 0, 3'b100, 2'b00, 2'b00,
                    7'b0010000);
      3: return vec(0, 0, 3'b000, 2'b00,
                    movr ? 2'b00 : o,
                    {3'b000, !cmp, cmp,
                     movr || mvn, 1'b0});
      default: return vec(0, 0, 3'b010, 2'b00,
                          2'b00, 7'b1000000);
    endcase
  endfunction

  bit         busy[2];
  bit         halted[2];
  int         pos[2];
  logic [2:0] m_opc[2];
  logic [1:0] m_op[2];

  task automatic model_edge(input int i,
                            input bit trap);
    if (reset) begin
      busy[i] = 0;
      halted[i] = 0;
    end else if (halted[i]) begin
      halted[i] = 1;
    end else if (busy[i]) begin
      pos[i]++;
      if (pos[i] == seq_len(m_opc[i], m_op[i])) begin
        busy[i] = 0;
        if (trap && seq_len(m_opc[i], m_op[i]) == 1)
          halted[i] = 1;
      end
    end else if (s) begin
      busy[i] = 1;
      pos[i] = 0;
      m_opc[i] = opcode;
      m_op[i] = op;
    end
  endtask

  function automatic logic [15:0] model_out(int i);
    if (halted[i]) return HALTV;
    if (busy[i]) return seq_at(m_opc[i], m_op[i], pos[i]);
    return IDLE;
  endfunction

  function automatic logic [15:0] inv(
    logic wr, logic la, logic lb, logic lc,
    logic [2:0] n);
    logic [2:0] f;
    f[0] = $countones({wr, la, lb, lc}) > 1;
    f[1] = wr && n == 3'b100;
    f[2] = !$onehot0(n);
    return {13'b0, f};
  endfunction

  task automatic step(input logic r, input logic sv,
                      input logic [2:0] c,
                      input logic [1:0] o);
    reset = r;
    s = sv;
    opcode = c;
    op = o;
    @(posedge clk);
    model_edge(0, 1'b0);
    model_edge(1, 1'b1);
    #1;
    check("out", {w0, err0, nsel0, vsel0, alu0,
                  write0, loada0, loadb0, loadc0,
                  loads0, asel0, bsel0},
          model_out(0));
    check("out_trap", {w1, err1, nsel1, vsel1, alu1,
                       write1, loada1, loadb1, loadc1,
                       loads1, asel1, bsel1},
          model_out(1));
    check("inv", inv(write0, loada0, loadb0,
                     loadc0, nsel0), 16'h0);
    check("inv_trap", inv(write1, loada1, loadb1,
                          loadc1, nsel1), 16'h0);
  endtask

  logic [4:0] legal_tbl [6] = '{
    5'b110_10, 5'b110_00, 5'b101_00,
    5'b101_01, 5'b101_10, 5'b101_11};

  initial begin
    step(1, 0, 3'b000, 2'b00);
    step(1, 1, 3'b110, 2'b10);
    step(1, 1, 3'b110, 2'b10);
    // MOVI; opcode flips during DECODE
    step(0, 1, 3'b110, 2'b10);
    step(0, 0, 3'b101, 2'b00);
    step(0, 0, 3'b101, 2'b00);
    step(0, 0, 3'b000, 2'b00);
    // ADD
    step(0, 1, 3'b101, 2'b00);
    for (int i = 0; i < 6; i++)
      step(0, 0, 3'b111, 2'b11);
    // CMP then MVN with s held high
    step(0, 1, 3'b101, 2'b01);
    for (int i = 0; i < 10; i++)
      step(0, 1, 3'b101, 2'b11);
    step(0, 0, 3'b000, 2'b00);
    for (int i = 0; i < 5; i++)
      step(0, 0, 3'b000, 2'b00);
    // illegal: pulse vs trap
    step(0, 1, 3'b011, 2'b00);
    for (int i = 0; i < 20; i++)
      step(0, 0, 3'b000, 2'b00);
    step(1, 0, 3'b000, 2'b00);
    step(0, 0, 3'b000, 2'b00);
    // AND, reset during GET_B, then MOVR
    step(0, 1, 3'b101, 2'b10);
    step(0, 0, 3'b101, 2'b10);
    step(0, 0, 3'b101, 2'b10);
    step(1, 0, 3'b101, 2'b10);
    step(0, 1, 3'b110, 2'b00);
    for (int i = 0; i < 5; i++)
      step(0, 0, 3'b000, 2'b00);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [4:0] pick;
      logic r;
      r = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 9) < 8)
        pick = legal_tbl[$urandom_range(0, 5)];
      else
        pick = 5'($urandom);
      step(r, 1'($urandom), pick[4:2], pick[1:0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
